// File: rtl/obi_mem_arbiter.sv
// Two-master OBI arbiter sharing one memory port, with grant lock and in-order response routing.
// Define OBI_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority data > instr.
module obi_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [3:0]  outstanding_o,
    output logic        err_o
);

    localparam int              PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [3:0]      MAX_CNT  = 4'(MAX_OUTSTANDING);
    localparam logic [PW-1:0]   LAST_PTR = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} lock_state_e;

    lock_state_e   r_state, w_state_nxt;
    logic [3:0]    r_count;
    logic [PW-1:0] r_wptr, r_rptr;
    logic          r_ids [MAX_OUTSTANDING];
    logic          r_err;

    logic w_sel_data, w_both_pick, w_full, w_sel_req, w_mem_req;
    logic w_push, w_pop, w_head_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

`ifdef OBI_ARB_ROUND_ROBIN_EN
    // Remembers the last granted requester; the other one wins the next contention.
    logic r_last_data;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       r_last_data <= 1'b0;
        else if (w_push) r_last_data <= w_sel_data;
    end
    assign w_both_pick = ~r_last_data;
`else
    assign w_both_pick = 1'b1;
`endif

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_sel_data = data_req_i;
        case (r_state)
            LOCK_I:  w_sel_data = 1'b0;
            LOCK_D:  w_sel_data = 1'b1;
            default: w_sel_data = (instr_req_i && data_req_i) ? w_both_pick : data_req_i;
        endcase
    end

    // Full is judged on the registered count only, so a pop never frees a slot the same cycle.
    assign w_full      = (r_count >= MAX_CNT);
    assign w_sel_req   = w_sel_data ? data_req_i : instr_req_i;
    assign w_mem_req   = w_sel_req & ~w_full & ~rst_i;
    assign w_push      = w_mem_req & mem_gnt_i;
    assign w_pop       = mem_rvalid_i & (r_count != 4'd0) & ~rst_i;
    assign w_head_data = r_ids[r_rptr];

    assign mem_req_o   = w_mem_req;
    assign mem_we_o    = w_sel_data ? data_we_i    : 1'b0;
    assign mem_be_o    = w_sel_data ? data_be_i    : 4'hF;
    assign mem_addr_o  = w_sel_data ? data_addr_i  : instr_addr_i;
    assign mem_wdata_o = w_sel_data ? data_wdata_i : 32'h0;

    assign instr_gnt_o    = w_push & ~w_sel_data;
    assign data_gnt_o     = w_push & w_sel_data;
    assign instr_rvalid_o = w_pop & ~w_head_data;
    assign data_rvalid_o  = w_pop & w_head_data;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign outstanding_o  = r_count;
    assign err_o          = r_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:           if (w_mem_req && !mem_gnt_i) w_state_nxt = w_sel_data ? LOCK_D : LOCK_I;
            LOCK_I, LOCK_D: if (mem_gnt_i) w_state_nxt = IDLE;
            default:        w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_count <= 4'd0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
            if (mem_rvalid_i && r_count == 4'd0) r_err <= 1'b1;
        end
    end

    // NOTE: the ID storage has no reset; entries are only read while the count marks them valid.
    always_ff @(posedge clk_i) begin
        if (w_push) r_ids[r_wptr] <= w_sel_data;
    end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Self-checking bench for obi_mem_arbiter: directed scenarios with literal expectations plus
// randomized OBI-compliant traffic checked every cycle against a queue-based reference model.
module tb_obi_mem_arbiter;

    localparam int MAX_OUT = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0, data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'hF;
    logic [31:0] data_addr_i = '0, data_wdata_i = '0;
    logic        data_gnt_o, data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [3:0]  outstanding_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    obi_mem_arbiter #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: queue of source IDs (1 = data), lock owner (0 none, 1 instr, 2 data).
    bit m_q[$];
    int m_owner     = 0;
    bit m_last_data = 1'b0;
    bit m_err       = 1'b0;

    always @(negedge clk_i) begin : compare
        bit e_sel_data, e_sel_req, e_mreq, e_full, e_pop, e_head, e_stray, e_push;
        if (rst_i) begin
            check("rst mem_req", mem_req_o, 0);
            check("rst instr_gnt", instr_gnt_o, 0);
            check("rst data_gnt", data_gnt_o, 0);
            check("rst instr_rvalid", instr_rvalid_o, 0);
            check("rst data_rvalid", data_rvalid_o, 0);
            check("rst outstanding", outstanding_o, 0);
            check("rst err", err_o, 0);
            m_q.delete();
            m_owner     = 0;
            m_last_data = 1'b0;
            m_err       = 1'b0;
        end else begin
            e_full = (m_q.size() >= MAX_OUT);
            if (m_owner == 1)                    e_sel_data = 1'b0;
            else if (m_owner == 2)               e_sel_data = 1'b1;
            else if (instr_req_i && data_req_i) begin
`ifdef OBI_ARB_ROUND_ROBIN_EN
                e_sel_data = !m_last_data;
`else
                e_sel_data = 1'b1;
`endif
            end else                             e_sel_data = data_req_i;
            e_sel_req = e_sel_data ? data_req_i : instr_req_i;
            e_mreq    = e_sel_req && !e_full;
            e_push    = e_mreq && mem_gnt_i;
            e_stray   = mem_rvalid_i && (m_q.size() == 0);
            e_pop     = mem_rvalid_i && (m_q.size() > 0);
            e_head    = (m_q.size() > 0) ? m_q[0] : 1'b0;

            check("mdl mem_req", mem_req_o, e_mreq);
            check("mdl instr_gnt", instr_gnt_o, e_push && !e_sel_data);
            check("mdl data_gnt", data_gnt_o, e_push && e_sel_data);
            check("mdl instr_rvalid", instr_rvalid_o, e_pop && !e_head);
            check("mdl data_rvalid", data_rvalid_o, e_pop && e_head);
            check("mdl instr_rdata", instr_rdata_o, mem_rdata_i);
            check("mdl data_rdata", data_rdata_o, mem_rdata_i);
            check("mdl outstanding", outstanding_o, m_q.size());
            check("mdl err", err_o, m_err);
            if (e_mreq) begin
                check("mdl mem_addr", mem_addr_o, e_sel_data ? data_addr_i : instr_addr_i);
                check("mdl mem_we", mem_we_o, e_sel_data ? data_we_i : 1'b0);
                check("mdl mem_be", mem_be_o, e_sel_data ? data_be_i : 4'hF);
                check("mdl mem_wdata", mem_wdata_o, e_sel_data ? data_wdata_i : 32'h0);
            end

            if (e_pop)   void'(m_q.pop_front());
            if (e_push)  m_q.push_back(e_sel_data);
            if (e_stray) m_err = 1'b1;
            if (e_push)  m_last_data = e_sel_data;
            if (m_owner == 0) begin
                if (e_mreq && !mem_gnt_i) m_owner = e_sel_data ? 2 : 1;
            end else if (mem_gnt_i) begin
                m_owner = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bit ig, dg, exp_d;
        ig = 1'b0;
        dg = 1'b0;

        // Reset state; requests are ignored while reset is high.
        repeat (2) @(posedge clk_i);
        #1;
        instr_req_i = 1'b1; mem_gnt_i = 1'b1;
        #1;
        check("reset mem_req", mem_req_o, 0);
        check("reset instr_gnt", instr_gnt_o, 0);
        check("reset outstanding", outstanding_o, 0);
        check("reset err", err_o, 0);
        step(); rst_i = 1'b0; instr_req_i = 1'b0; mem_gnt_i = 1'b0;

        // Single instruction read.
        step(); instr_req_i = 1'b1; instr_addr_i = 32'h0020_0000; mem_gnt_i = 1'b1; #1;
        check("rd instr_gnt", instr_gnt_o, 1);
        check("rd data_gnt", data_gnt_o, 0);
        check("rd mem_addr", mem_addr_o, 32'h0020_0000);
        check("rd mem_be", mem_be_o, 4'hF);
        check("rd mem_we", mem_we_o, 0);
        step(); instr_req_i = 1'b0; mem_gnt_i = 1'b0; #1;
        check("rd outstanding", outstanding_o, 1);
        step(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; #1;
        check("rd instr_rvalid", instr_rvalid_o, 1);
        check("rd instr_rdata", instr_rdata_o, 32'hDEAD_BEEF);
        check("rd data_rvalid", data_rvalid_o, 0);
        step(); mem_rvalid_i = 1'b0; #1;
        check("rd drained", outstanding_o, 0);

        // Contention with immediate grants.
        step(); instr_req_i = 1'b1; data_req_i = 1'b1; instr_addr_i = 32'h100; data_addr_i = 32'h200;
        mem_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin step(); mem_rvalid_i = 1'b1; end
            #1;
`ifdef OBI_ARB_ROUND_ROBIN_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            check($sformatf("arb%0d data_gnt", k), data_gnt_o, exp_d);
            check($sformatf("arb%0d instr_gnt", k), instr_gnt_o, !exp_d);
        end
        step(); instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        step(); mem_rvalid_i = 1'b0; #1;
        check("arb drained", outstanding_o, 0);

        // Lock: instr waits 3 cycles for grant while data arrives.
        step(); instr_req_i = 1'b1; instr_addr_i = 32'h1000; #1;
        check("lock c0 addr", mem_addr_o, 32'h1000);
        step(); data_req_i = 1'b1; data_addr_i = 32'h2000; data_we_i = 1'b1; data_be_i = 4'h3;
        data_wdata_i = 32'hCAFE_0001; #1;
        check("lock c1 addr", mem_addr_o, 32'h1000);
        check("lock c1 we", mem_we_o, 0);
        step(); #1;
        check("lock c2 addr", mem_addr_o, 32'h1000);
        step(); mem_gnt_i = 1'b1; #1;
        check("lock c3 instr_gnt", instr_gnt_o, 1);
        check("lock c3 data_gnt", data_gnt_o, 0);
        check("lock c3 addr", mem_addr_o, 32'h1000);
        step(); instr_req_i = 1'b0; #1;
        check("lock c4 data_gnt", data_gnt_o, 1);
        check("lock c4 addr", mem_addr_o, 32'h2000);
        check("lock c4 we", mem_we_o, 1);
        check("lock c4 be", mem_be_o, 4'h3);
        check("lock c4 wdata", mem_wdata_o, 32'hCAFE_0001);
        step(); data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'hF; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111; #1;
        check("lock rsp0 instr_rvalid", instr_rvalid_o, 1);
        check("lock rsp0 data_rvalid", data_rvalid_o, 0);
        step(); mem_rdata_i = 32'h2222_2222; #1;
        check("lock rsp1 data_rvalid", data_rvalid_o, 1);
        check("lock rsp1 data_rdata", data_rdata_o, 32'h2222_2222);
        check("lock rsp1 instr_rvalid", instr_rvalid_o, 0);

        // Outstanding limit.
        step(); mem_rvalid_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h3000; mem_gnt_i = 1'b1; #1;
        check("full g0", data_gnt_o, 1);
        step(); #1;
        check("full g1", data_gnt_o, 1);
        check("full g1 outstanding", outstanding_o, 1);
        step(); #1;
        check("full blocked mem_req", mem_req_o, 0);
        check("full blocked gnt", data_gnt_o, 0);
        check("full outstanding", outstanding_o, 2);
        step(); mem_rvalid_i = 1'b1; #1;
        check("full pop rvalid", data_rvalid_o, 1);
        check("full pop no passthru", data_gnt_o, 0);
        step(); mem_rvalid_i = 1'b0; #1;
        check("full after pop outstanding", outstanding_o, 1);
        check("full after pop gnt", data_gnt_o, 1);
        step(); data_req_i = 1'b0; mem_gnt_i = 1'b0; #1;
        check("pre-reset outstanding", outstanding_o, 2);

        // Reset with two outstanding.
        rst_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; #1;
        check("midrst outstanding", outstanding_o, 0);
        check("midrst mem_req", mem_req_o, 0);
        check("midrst data_gnt", data_gnt_o, 0);
        check("midrst data_rvalid", data_rvalid_o, 0);
        check("midrst instr_rvalid", instr_rvalid_o, 0);
        step(); rst_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        step(); instr_req_i = 1'b1; instr_addr_i = 32'h4000; mem_gnt_i = 1'b1; #1;
        check("postrst instr_gnt", instr_gnt_o, 1);
        check("postrst addr", mem_addr_o, 32'h4000);
        step(); instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BAD_F00D; #1;
        check("postrst instr_rvalid", instr_rvalid_o, 1);
        check("postrst err", err_o, 0);
        step(); mem_rvalid_i = 1'b0; #1;
        check("postrst drained", outstanding_o, 0);

        // Interleaved I, D, I with in-order routing, then a stray response.
        step(); instr_req_i = 1'b1; instr_addr_i = 32'h5000; mem_gnt_i = 1'b1; #1;
        check("il g0 instr", instr_gnt_o, 1);
        step(); instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h6000; #1;
        check("il g1 data", data_gnt_o, 1);
        step(); data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; #1;
        check("il r0 instr", instr_rvalid_o, 1);
        check("il r0 data", data_rvalid_o, 0);
        step(); instr_req_i = 1'b1; instr_addr_i = 32'h7000; mem_gnt_i = 1'b1; #1;
        check("il g2 instr", instr_gnt_o, 1);
        check("il r1 data", data_rvalid_o, 1);
        check("il r1 instr", instr_rvalid_o, 0);
        step(); instr_req_i = 1'b0; mem_gnt_i = 1'b0; #1;
        check("il r2 instr", instr_rvalid_o, 1);
        check("il r2 data", data_rvalid_o, 0);
        step(); #1;
        check("stray instr_rvalid", instr_rvalid_o, 0);
        check("stray data_rvalid", data_rvalid_o, 0);
        check("stray outstanding", outstanding_o, 0);
        step(); mem_rvalid_i = 1'b0; #1;
        check("stray err set", err_o, 1);
        repeat (3) step();
        #1;
        check("stray err sticky", err_o, 1);
        rst_i = 1'b1;
        step(); rst_i = 1'b0; #1;
        check("stray err cleared", err_o, 0);

        // Randomized OBI-compliant traffic; requests stay stable until granted.
        for (int k = 0; k < 3000; k++) begin
            step();
            rst_i = (k == 1500);
            if (!instr_req_i || ig) begin
                instr_req_i = ($urandom_range(0, 9) < 4);
                instr_addr_i = $urandom;
            end
            if (!data_req_i || dg) begin
                data_req_i   = ($urandom_range(0, 9) < 4);
                data_addr_i  = $urandom;
                data_we_i    = $urandom_range(0, 1);
                data_be_i    = 4'($urandom_range(0, 15));
                data_wdata_i = $urandom;
            end
            mem_gnt_i    = ($urandom_range(0, 3) != 0);
            mem_rvalid_i = ((outstanding_o != 4'd0) && ($urandom_range(0, 1) == 1)) ||
                           ($urandom_range(0, 199) == 0);
            mem_rdata_i  = $urandom;
            #1;
            ig = instr_gnt_o;
            dg = data_gnt_o;
        end

        step();
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
